// File: rtl/spi_slave_eeprom.sv
// spi_slave_eeprom: SPI mode-0 slave fronting a small byte-wide EEPROM-like array.
//
// Command set: WREN 0x06, WRDI 0x04, RDSR 0x05, READ 0x03, WRITE 0x02.
// Writes commit instantaneously, so the WIP bit of the status register is always 0.
//
// Ports:
//   clk       system clock; all state updates on its rising edge
//   rst       asynchronous active-low reset
//   spi_sck   SPI clock from master (CPOL=0, CPHA=0), sampled through a synchroniser
//   spi_mosi  master-to-slave data, MSB first
//   spi_ss    active-low chip select
//   spi_miso  slave-to-master data, MSB first, registered
//   dbg_addr  backdoor read address
//   dbg_data  mem[dbg_addr], one clk of latency
//   busy      synchronised chip select is low
//   wel       write-enable latch
//
// state  | meaning
// IDLE   | deselected, waiting for a chip-select falling edge
// CMD    | receiving the command byte
// ADDR   | receiving the address byte (read or write flavour)
// WDATA  | receiving data bytes to write at ptr
// RDATA  | returning mem[ptr] bytes on MISO
// STATUS | returning the status register on MISO, repeated
// IGNORE | remainder of the transaction is ignored
module spi_slave_eeprom #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_ss,
  output logic              spi_miso,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data,
  output logic              busy,
  output logic              wel
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync, vld_sync;
  logic sck_s, mosi_s, ss_s;
  logic sck_d, ss_d;
  logic armed;

  logic [2:0]        bit_cnt;
  logic [7:0]        rx, rx_next;
  logic [7:0]        tx;
  logic [MEM_AW-1:0] ptr;
  logic              rd_flag;
  logic [7:0]        mem [DEPTH];

  logic active, sck_rise_v, sck_fall_v, ss_fall, ss_rise, byte_done;

  logic              wel_set, wel_clr, rd_set, wr_set;
  logic              ptr_load, ptr_inc, mem_we;
  logic [MEM_AW-1:0] ptr_val;
  logic              tx_load;
  logic [7:0]        tx_load_val;

  // ss synchroniser resets high so busy reads 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      vld_sync  <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
      // The reset value of the ss synchroniser is not a real sample; a chip
      // select already low at reset release must not look like a new frame.
      if (vld_sync[SYNC_STAGES-1] && ss_s)
        armed <= 1'b1;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign busy   = ~ss_s;

  // Qualifying with the previous ss sample lets an SCK edge that lands in the
  // same clk as the ss rising edge still complete its byte before IDLE.
  assign active     = (state != IDLE) && !ss_d;
  assign sck_rise_v = active && sck_s && !sck_d;
  assign sck_fall_v = active && !sck_s && sck_d;
  assign ss_fall    = armed && ss_d && !ss_s;
  assign ss_rise    = !ss_d && ss_s;
  assign byte_done  = sck_rise_v && (bit_cnt == 3'd7);
  assign rx_next    = {rx[6:0], mosi_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wel_set     = 1'b0;
    wel_clr     = 1'b0;
    rd_set      = 1'b0;
    wr_set      = 1'b0;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    ptr_val     = rx_next[MEM_AW-1:0];
    mem_we      = 1'b0;
    tx_load     = 1'b0;
    tx_load_val = 8'h00;
    case (state)
      IDLE: if (ss_fall) state_nxt = CMD;
      CMD: if (byte_done) begin
        case (rx_next)
          8'h06: begin wel_set = 1'b1; state_nxt = IGNORE; end
          8'h04: begin wel_clr = 1'b1; state_nxt = IGNORE; end
          8'h05: begin
            state_nxt   = STATUS;
            tx_load     = 1'b1;
            tx_load_val = {6'b0, wel, 1'b0};
          end
          8'h03: begin rd_set = 1'b1; state_nxt = ADDR; end
          8'h02: begin wr_set = 1'b1; state_nxt = ADDR; end
          default: state_nxt = IGNORE;
        endcase
      end
      ADDR: if (byte_done) begin
        ptr_load = 1'b1;
        if (rd_flag) begin
          // First read byte is fetched here, so ptr moves straight past it.
          state_nxt   = RDATA;
          tx_load     = 1'b1;
          tx_load_val = mem[rx_next[MEM_AW-1:0]];
          ptr_val     = rx_next[MEM_AW-1:0] + MEM_AW'(1);
        end else begin
          state_nxt = WDATA;
        end
      end
      WDATA: if (byte_done) begin
        mem_we  = wel;
        ptr_inc = 1'b1;
      end
      RDATA: if (byte_done) begin
        tx_load     = 1'b1;
        tx_load_val = mem[ptr];
        ptr_inc     = 1'b1;
      end
      STATUS: if (byte_done) begin
        tx_load     = 1'b1;
        tx_load_val = {6'b0, wel, 1'b0};
      end
      default: ;
    endcase
    if (ss_rise) begin
      if (state_nxt == WDATA) wel_clr = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      rx       <= 8'h00;
      tx       <= 8'h00;
      ptr      <= '0;
      rd_flag  <= 1'b0;
      wel      <= 1'b0;
      spi_miso <= 1'b0;
      dbg_data <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      if (ss_rise) begin
        bit_cnt <= 3'd0;
        rx      <= 8'h00;
      end else if (sck_rise_v) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx      <= rx_next;
      end

      if (tx_load)         tx <= tx_load_val;
      else if (sck_fall_v) tx <= {tx[6:0], 1'b0};

      if (ss_s || !(state == RDATA || state == STATUS)) spi_miso <= 1'b0;
      else if (sck_fall_v)                               spi_miso <= tx[7];

      if (ptr_load)     ptr <= ptr_val;
      else if (ptr_inc) ptr <= ptr + MEM_AW'(1);

      if (rd_set)      rd_flag <= 1'b1;
      else if (wr_set) rd_flag <= 1'b0;

      if (wel_set)      wel <= 1'b1;
      else if (wel_clr) wel <= 1'b0;

      if (mem_we) mem[ptr] <= rx_next;

      dbg_data <= mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_spi_slave_eeprom.sv
// Directed bench for spi_slave_eeprom: SPI master tasks drive mode-0 frames
// (SCK half-period 40 ns, clk period 10 ns) and expected values are hand-computed.
module tb_spi_slave_eeprom;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_miso;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;
  logic       busy;
  logic       wel;

  int checks = 0;
  int failures = 0;

  spi_slave_eeprom #(.SYNC_STAGES(2), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_ss(spi_ss), .spi_miso(spi_miso), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .busy(busy), .wel(wel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic spi_begin();
    spi_ss = 1'b0;
    #40;
  endtask

  task automatic spi_end();
    #40 spi_ss = 1'b1;
    #120;
  endtask

  // Shifts the top n bits of b (MSB first); r collects MISO sampled at each rise.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #40 spi_sck = 1'b1;
      r = {r[6:0], spi_miso};
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    spi_bits(b, 8, r);
  endtask

  task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #20;
    check_val(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [7:0] r;
    spi_begin();
    spi_byte(c, r);
    spi_end();
  endtask

  initial begin
    logic [7:0] r;

    #20;
    check_val("rst_miso", {31'h0, spi_miso}, 32'h0);
    check_val("rst_wel", {31'h0, wel}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_dbg", {24'h0, dbg_data}, 32'h0);
    #10 rst = 1'b1;
    #50;
    check_mem("mem0_init", 8'h00, 8'hFF);

    // WREN / RDSR / WRDI
    send_cmd(8'h06);
    check_val("wren_wel", {31'h0, wel}, 32'h1);
    spi_begin();
    check_val("busy_sel", {31'h0, busy}, 32'h1);
    spi_byte(8'h05, r);
    spi_byte(8'h00, r);
    check_val("rdsr_wel1", {24'h0, r}, 32'h02);
    spi_byte(8'h00, r);
    check_val("rdsr_rep", {24'h0, r}, 32'h02);
    spi_end();
    send_cmd(8'h04);
    check_val("wrdi_wel", {31'h0, wel}, 32'h0);
    spi_begin();
    spi_byte(8'h05, r);
    spi_byte(8'h00, r);
    check_val("rdsr_wel0", {24'h0, r}, 32'h00);
    spi_end();

    // Write then read at 0xFE
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'hFE, r);
    spi_byte(8'hD3, r);
    spi_end();
    check_mem("wr_fe", 8'hFE, 8'hD3);
    check_val("wr_wel_clr", {31'h0, wel}, 32'h0);
    spi_begin();
    spi_byte(8'h03, r);
    check_val("rd_cmd_miso", {24'h0, r}, 32'h00);
    spi_byte(8'hFE, r);
    check_val("rd_addr_miso", {24'h0, r}, 32'h00);
    spi_byte(8'h00, r);
    check_val("rd_fe", {24'h0, r}, 32'hD3);
    spi_byte(8'h00, r);
    check_val("rd_ff", {24'h0, r}, 32'hFF);
    spi_end();

    // Address wrap
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'hFF, r);
    spi_byte(8'h11, r);
    spi_byte(8'h22, r);
    spi_end();
    check_mem("wrap_ff", 8'hFF, 8'h11);
    check_mem("wrap_00", 8'h00, 8'h22);
    spi_begin();
    spi_byte(8'h03, r);
    spi_byte(8'hFF, r);
    spi_byte(8'h00, r);
    check_val("rdwrap_0", {24'h0, r}, 32'h11);
    spi_byte(8'h00, r);
    check_val("rdwrap_1", {24'h0, r}, 32'h22);
    spi_end();

    // Write protection
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h10, r);
    spi_byte(8'h5A, r);
    spi_end();
    check_mem("wprot_10", 8'h10, 8'hFF);

    // Unknown command leaves MISO low
    spi_begin();
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r);
    check_val("ignore_miso", {24'h0, r}, 32'h00);
    spi_end();

    // WRITE reaching WDATA with no data still clears wel
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h40, r);
    spi_end();
    check_val("wdata_nodata_wel", {31'h0, wel}, 32'h0);
    check_mem("nodata_40", 8'h40, 8'hFF);

    // Partial-byte abort
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h20, r);
    spi_byte(8'hAB, r);
    spi_bits(8'h55, 4, r);
    spi_end();
    check_mem("abort_20", 8'h20, 8'hAB);
    check_mem("abort_21", 8'h21, 8'hFF);

    // Reset pulse mid-byte, chip select held low across release
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h30, r);
    spi_bits(8'h77, 4, r);
    rst = 1'b0;
    #20 rst = 1'b1;
    #20;
    check_val("rstmid_wel", {31'h0, wel}, 32'h0);
    spi_bits(8'h70, 4, r);
    spi_byte(8'h66, r);
    spi_end();
    check_mem("rstmid_30", 8'h30, 8'hFF);
    check_mem("rstmid_31", 8'h31, 8'hFF);

    // Resumes normally on the next frame
    send_cmd(8'h06);
    spi_begin();
    spi_byte(8'h02, r);
    spi_byte(8'h30, r);
    spi_byte(8'h3C, r);
    spi_end();
    check_mem("resume_30", 8'h30, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
